// File: rtl/dsp_post_adder_acc.sv
// Post-adder/accumulator stage of the DSP slice: selects X/Z operands, adds or
// subtracts with carry-in, and optionally registers the result for accumulation.
module dsp_post_adder_acc #(
  parameter int PREG   = 1,
  parameter int WIDTH  = 48,
  parameter int MWIDTH = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cep,
  input  logic              cecarryout,
  input  logic [7:0]        opmode,
  input  logic [MWIDTH-1:0] m,
  input  logic [WIDTH-1:0]  c,
  input  logic [WIDTH-1:0]  dab,
  input  logic [WIDTH-1:0]  pcin,
  input  logic              carryin,
  output logic [WIDTH-1:0]  p,
  output logic [WIDTH-1:0]  pcout,
  output logic              carryout,
  output logic              carryoutf
);

  logic [WIDTH-1:0] mExt;
  logic [WIDTH-1:0] feedback;
  logic [WIDTH-1:0] xOp;
  logic [WIDTH-1:0] zOp;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             unusedOpmode;

  assign mExt         = {{(WIDTH-MWIDTH){m[MWIDTH-1]}}, m};
  assign unusedOpmode = ^opmode[6:4];

  always_comb begin
    xOp = '0;
    zOp = '0;
    case (opmode[1:0])
      2'd1:    xOp = mExt;
      2'd2:    xOp = feedback;
      2'd3:    xOp = dab;
      default: xOp = '0;
    endcase
    case (opmode[3:2])
      2'd1:    zOp = pcin;
      2'd2:    zOp = feedback;
      2'd3:    zOp = c;
      default: zOp = '0;
    endcase
  end

  // Operands are zero-extended so bit WIDTH is a carry on add and a borrow on subtract.
  always_comb begin
    sum = '0;
    if (opmode[7])
      sum = {1'b0, zOp} - ({1'b0, xOp} + {{WIDTH{1'b0}}, carryin});
    else
      sum = {1'b0, zOp} + {1'b0, xOp} + {{WIDTH{1'b0}}, carryin};
  end

  assign result = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];

  generate
    if (PREG != 0) begin : gPreg
      logic [WIDTH-1:0] p_q;
      logic [WIDTH-1:0] p_d;
      logic             carry_q;
      logic             carry_d;

      assign p_d     = cep ? result : p_q;
      assign carry_d = cecarryout ? carry : carry_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_q     <= '0;
          carry_q <= 1'b0;
        end else begin
          p_q     <= p_d;
          carry_q <= carry_d;
        end
      end

      assign p        = p_q;
      assign carryout = carry_q;
      assign feedback = p_q;
    end else begin : gBypass
      logic unusedCtrl;

      // Feedback would form a combinational loop here, so it reads as zero.
      assign unusedCtrl = ^{clk, rst, cep, cecarryout};
      assign p          = result;
      assign carryout   = carry;
      assign feedback   = '0;
    end
  endgenerate

  assign pcout     = p;
  assign carryoutf = carryout;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Scoreboard bench for dsp_post_adder_acc: registered (PREG=1) and bypass
// (PREG=0) instances share stimulus and are checked against an arithmetic model.
module tb_dsp_post_adder_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        cep;
  logic        cecarryout;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] c;
  logic [47:0] dab;
  logic [47:0] pcin;
  logic        carryin;
  logic [47:0] p;
  logic [47:0] pcout;
  logic        carryout;
  logic        carryoutf;
  logic [47:0] pB;
  logic [47:0] pcoutB;
  logic        carryoutB;
  logic        carryoutfB;

  typedef struct {
    logic [47:0] p;
    logic        c;
  } exp_t;

  exp_t        expQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [47:0] modelP;
  logic        modelC;

  dsp_post_adder_acc #(.PREG(1), .WIDTH(48), .MWIDTH(36)) dut (
    .clk(clk), .rst(rst), .cep(cep), .cecarryout(cecarryout), .opmode(opmode),
    .m(m), .c(c), .dab(dab), .pcin(pcin), .carryin(carryin),
    .p(p), .pcout(pcout), .carryout(carryout), .carryoutf(carryoutf)
  );

  dsp_post_adder_acc #(.PREG(0), .WIDTH(48), .MWIDTH(36)) dutBypass (
    .clk(clk), .rst(rst), .cep(cep), .cecarryout(cecarryout), .opmode(opmode),
    .m(m), .c(c), .dab(dab), .pcin(pcin), .carryin(carryin),
    .p(pB), .pcout(pcoutB), .carryout(carryoutB), .carryoutf(carryoutfB)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit integer arithmetic; bit 48 is the carry/borrow.
  function automatic logic [48:0] refCalc(input logic [7:0] op, input logic [47:0] fb);
    logic [63:0] x;
    logic [63:0] z;
    logic [63:0] r;
    logic [47:0] me;
    me = 48'($signed(m));
    case (op[1:0])
      2'd0:    x = 64'd0;
      2'd1:    x = {16'd0, me};
      2'd2:    x = {16'd0, fb};
      default: x = {16'd0, dab};
    endcase
    case (op[3:2])
      2'd0:    z = 64'd0;
      2'd1:    z = {16'd0, pcin};
      2'd2:    z = {16'd0, fb};
      default: z = {16'd0, c};
    endcase
    if (op[7]) r = z - x - {63'd0, carryin};
    else       r = z + x + {63'd0, carryin};
    return r[48:0];
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] act, input logic [47:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [35:0] mm, input logic [47:0] cc,
                               input logic [47:0] dd, input logic [47:0] pp, input logic ci,
                               input logic ce, input logic cec);
    logic [48:0] r;
    logic [48:0] rb;
    @(negedge clk);
    opmode = op; m = mm; c = cc; dab = dd; pcin = pp; carryin = ci;
    cep = ce; cecarryout = cec;
    r = refCalc(op, modelP);
    if (ce)  modelP = r[47:0];
    if (cec) modelC = r[48];
    expQ.push_back('{modelP, modelC});
    #1;
    rb = refCalc(op, 48'd0);
    checkOutput("bypassP", pB, rb[47:0]);
    checkOutput("bypassPcout", pcoutB, rb[47:0]);
    checkOutput("bypassCarry", {47'd0, carryoutB}, {47'd0, rb[48]});
    checkOutput("bypassCarryF", {47'd0, carryoutfB}, {47'd0, rb[48]});
  endtask

  task automatic afterEdge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: registered outputs are compared one edge after each stimulus.
  always begin : monitor
    exp_t e;
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("p", p, e.p);
      checkOutput("pcout", pcout, e.p);
      checkOutput("carryout", {47'd0, carryout}, {47'd0, e.c});
      checkOutput("carryoutf", {47'd0, carryoutf}, {47'd0, e.c});
    end
  end

  initial begin
    logic [63:0] r64;
    logic [63:0] s64;
    logic [63:0] t64;
    rst = 1'b1; cep = 1'b1; cecarryout = 1'b1; opmode = 8'h00;
    m = '0; c = '0; dab = '0; pcin = '0; carryin = 1'b0;
    modelP = '0; modelC = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("resetP", p, 48'd0);
    checkOutput("resetCarry", {47'd0, carryout}, 48'd0);
    rst = 1'b0;

    // Cascade with enable held low, then loaded.
    applyStimulus(8'h04, 36'd0, 48'd0, 48'd0, 48'h1234, 1'b0, 1'b0, 1'b0);
    afterEdge();
    checkOutput("cascadeHold", p, 48'd0);
    applyStimulus(8'h04, 36'd0, 48'd0, 48'd0, 48'h1234, 1'b0, 1'b1, 1'b1);
    afterEdge();
    checkOutput("cascadeLoad", pcout, 48'h1234);

    // Clear, then multiply-accumulate.
    applyStimulus(8'h00, 36'd0, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      applyStimulus(8'h09, 36'd3, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    afterEdge();
    checkOutput("mac15", p, 48'd15);
    applyStimulus(8'h09, 36'hF_FFFF_FFFE, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    afterEdge();
    checkOutput("mac13", p, 48'd13);

    applyStimulus(8'h8F, 36'd0, 48'd5, 48'd7, 48'd0, 1'b0, 1'b1, 1'b1);
    afterEdge();
    checkOutput("borrowP", p, 48'hFFFF_FFFF_FFFE);
    checkOutput("borrowCarry", {47'd0, carryout}, 48'd1);

    // Asynchronous reset between edges, with enables still high.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncResetP", p, 48'd0);
    checkOutput("asyncResetCarry", {47'd0, carryout}, 48'd0);
    afterEdge();
    checkOutput("resetWinsP", p, 48'd0);
    checkOutput("bypassIgnoresReset", pB, 48'hFFFF_FFFF_FFFE);
    @(negedge clk);
    cep = 1'b0; cecarryout = 1'b0;
    rst = 1'b0;
    modelP = '0; modelC = 1'b0;

    applyStimulus(8'h8F, 36'd0, 48'd10, 48'd3, 48'd0, 1'b1, 1'b1, 1'b1);
    afterEdge();
    checkOutput("subP", p, 48'd6);
    checkOutput("subCarry", {47'd0, carryout}, 48'd0);

    applyStimulus(8'h0D, 36'd1, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    afterEdge();
    checkOutput("wrapP", p, 48'd0);
    checkOutput("wrapCarry", {47'd0, carryout}, 48'd1);
    applyStimulus(8'h0D, 36'd1, 48'd5, 48'd0, 48'd0, 1'b0, 1'b1, 1'b0);
    afterEdge();
    checkOutput("carryHoldP", p, 48'd6);
    checkOutput("carryHold", {47'd0, carryout}, 48'd1);

    applyStimulus(8'h0D, 36'hF_FFFF_FFFF, 48'd100, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("bypass99", pB, 48'd99);
    applyStimulus(8'h0A, 36'd5, 48'd0, 48'd0, 48'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("bypassFeedback", pB, 48'd0);

    for (int i = 0; i < 300; i++) begin
      r64 = {$urandom(), $urandom()};
      s64 = {$urandom(), $urandom()};
      t64 = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) s64[47:0] = 48'hFFFF_FFFF_FFFF;
      applyStimulus(8'($urandom()), r64[35:0], s64[47:0], t64[47:0], {r64[63:48], s64[63:32]},
                    1'($urandom()), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
